// File: rtl/alu_opy_if.sv
// Operand-Y stage bus: upstream request side and ALU-facing pair side.
interface alu_opy_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_SRC);

  logic                     IN_VALID;
  logic                     IN_READY;
  logic [WIDTH-1:0]         OPX_IN;
  logic [NUM_SRC*WIDTH-1:0] SRC_BUS;
  logic [SEL_W-1:0]         OPY_SEL;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic [WIDTH-1:0]         OPX_OUT;
  logic [WIDTH-1:0]         OPY_OUT;
  logic                     SEL_ERR;
  logic [CNT_W-1:0]         ERR_CNT;

  // Driver of requests and consumer of pairs (upstream + ALU side)
  modport master (
    output IN_VALID, OPX_IN, SRC_BUS, OPY_SEL, OUT_READY,
    input  IN_READY, OUT_VALID, OPX_OUT, OPY_OUT, SEL_ERR, ERR_CNT
  );

  // The operand-Y stage itself
  modport slave (
    input  IN_VALID, OPX_IN, SRC_BUS, OPY_SEL, OUT_READY,
    output IN_READY, OUT_VALID, OPX_OUT, OPY_OUT, SEL_ERR, ERR_CNT
  );
endinterface

// File: rtl/alu_opy_stage.sv
// Operand-Y select stage: picks Y from NUM_SRC sources, pairs it with X and
// hands the pair to the ALU through a 2-entry valid/ready skid buffer.
module alu_opy_stage #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic   CLK,
  input logic   RST,
  alu_opy_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             err;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  pair_t            main_q, main_d;
  pair_t            skid_q, skid_d;
  pair_t            new_pair;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W:0]   sel_ext;
  logic             push, pop;

  // Operand-Y mux; out-of-range selects match no source and yield zero
  always_comb begin
    new_pair.x   = bus.OPX_IN;
    new_pair.y   = '0;
    sel_ext      = {1'b0, bus.OPY_SEL};
    new_pair.err = (sel_ext >= (SEL_W+1)'(NUM_SRC));
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (bus.OPY_SEL == SEL_W'(i)) new_pair.y = bus.SRC_BUS[i*WIDTH +: WIDTH];
    end
  end

  assign push = bus.IN_VALID & in_ready_q;
  assign pop  = out_valid_q & bus.OUT_READY;

  // Skid-buffer next state, storage updates and saturating error count
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = new_pair;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = new_pair;
        end else if (push) begin
          skid_d  = new_pair;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (push && new_pair.err && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State and storage registers; reset discards any in-flight pairs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OPX_OUT   = main_q.x;
  assign bus.OPY_OUT   = main_q.y;
  assign bus.SEL_ERR   = main_q.err;
  assign bus.ERR_CNT   = cnt_q;
endmodule

// File: tb/tb_alu_opy_stage.sv
// Directed bench for alu_opy_stage: NUM_SRC=4 and NUM_SRC=3 instances.
module tb_alu_opy_stage;
  logic CLK;
  logic RST;
  int   n_assert;
  int   n_fail;

  logic [7:0] src_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  alu_opy_if #(.WIDTH(8), .NUM_SRC(4), .CNT_W(8)) ifa ();
  alu_opy_if #(.WIDTH(8), .NUM_SRC(3), .CNT_W(8)) ifb ();

  alu_opy_stage #(.WIDTH(8), .NUM_SRC(4), .CNT_W(8)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ifa)
  );

  alu_opy_stage #(.WIDTH(8), .NUM_SRC(3), .CNT_W(8)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ifb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RST = 1'b1;
    ifa.IN_VALID = 1'b0; ifa.OPX_IN = '0; ifa.OPY_SEL = '0; ifa.OUT_READY = 1'b0;
    ifa.SRC_BUS = {8'h44, 8'h33, 8'h22, 8'h11};
    ifb.IN_VALID = 1'b0; ifb.OPX_IN = '0; ifb.OPY_SEL = '0; ifb.OUT_READY = 1'b1;
    ifb.SRC_BUS = {8'h33, 8'h22, 8'h11};

    // Reset values, before any clock edge
    #3;
    chk("rst_out_valid", 32'(ifa.OUT_VALID), 32'd0);
    chk("rst_in_ready",  32'(ifa.IN_READY),  32'd1);
    chk("rst_opx",       32'(ifa.OPX_OUT),   32'd0);
    chk("rst_err_cnt",   32'(ifa.ERR_CNT),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Single pass
    ifa.OUT_READY = 1'b1;
    ifa.IN_VALID = 1'b1; ifa.OPY_SEL = 2'd2; ifa.OPX_IN = 8'hA5;
    tick();
    ifa.IN_VALID = 1'b0;
    chk("single_valid", 32'(ifa.OUT_VALID), 32'd1);
    chk("single_opy",   32'(ifa.OPY_OUT),   32'h33);
    chk("single_opx",   32'(ifa.OPX_OUT),   32'hA5);
    chk("single_err",   32'(ifa.SEL_ERR),   32'd0);
    tick();
    chk("single_drain", 32'(ifa.OUT_VALID), 32'd0);

    // Backpressure into the skid register
    ifa.OUT_READY = 1'b0;
    ifa.IN_VALID = 1'b1; ifa.OPY_SEL = 2'd0; ifa.OPX_IN = 8'h01;
    tick();
    chk("bp_ready_one", 32'(ifa.IN_READY), 32'd1);
    ifa.OPY_SEL = 2'd3; ifa.OPX_IN = 8'h02;
    tick();
    ifa.OPY_SEL = 2'd1; ifa.OPX_IN = 8'h03;   // offered while full, must be ignored
    chk("bp_ready_full", 32'(ifa.IN_READY), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_opy", 32'(ifa.OPY_OUT), 32'h11);
      chk("bp_hold_opx", 32'(ifa.OPX_OUT), 32'h01);
      tick();
    end
    ifa.IN_VALID = 1'b0;
    chk("bp_hold_valid", 32'(ifa.OUT_VALID), 32'd1);
    ifa.OUT_READY = 1'b1;
    tick();
    chk("bp_second_opy",  32'(ifa.OPY_OUT),   32'h44);
    chk("bp_second_opx",  32'(ifa.OPX_OUT),   32'h02);
    chk("bp_second_vld",  32'(ifa.OUT_VALID), 32'd1);
    chk("bp_ready_back",  32'(ifa.IN_READY),  32'd1);
    tick();
    chk("bp_no_extra", 32'(ifa.OUT_VALID), 32'd0);

    // Streaming at one pair per cycle
    for (int k = 0; k < 16; k++) begin
      ifa.IN_VALID = 1'b1; ifa.OPY_SEL = 2'(k % 4); ifa.OPX_IN = 8'(k + 16);
      tick();
      chk("stream_ready", 32'(ifa.IN_READY),  32'd1);
      chk("stream_valid", 32'(ifa.OUT_VALID), 32'd1);
      chk("stream_opx",   32'(ifa.OPX_OUT),   32'(k + 16));
      chk("stream_opy",   32'(ifa.OPY_OUT),   32'(src_a[k % 4]));
    end
    ifa.IN_VALID = 1'b0;
    tick();
    chk("stream_drain", 32'(ifa.OUT_VALID), 32'd0);

    // Out-of-range select on the 3-source instance
    ifb.IN_VALID = 1'b1; ifb.OPY_SEL = 2'd2; ifb.OPX_IN = 8'h5A;
    tick();
    chk("b_inrange_opy", 32'(ifb.OPY_OUT), 32'h33);
    chk("b_inrange_err", 32'(ifb.SEL_ERR), 32'd0);
    chk("b_inrange_cnt", 32'(ifb.ERR_CNT), 32'd0);
    ifb.OPY_SEL = 2'd3;
    tick();
    chk("b_oor_opy", 32'(ifb.OPY_OUT), 32'd0);
    chk("b_oor_err", 32'(ifb.SEL_ERR), 32'd1);
    chk("b_oor_opx", 32'(ifb.OPX_OUT), 32'h5A);
    chk("b_oor_cnt", 32'(ifb.ERR_CNT), 32'd1);
    for (int n = 2; n <= 300; n++) begin
      tick();
      if (n == 254 || n == 255 || n == 256 || n == 300)
        chk("b_cnt_sat", 32'(ifb.ERR_CNT), (n < 255) ? 32'(n) : 32'd255);
    end
    ifb.IN_VALID = 1'b0;
    tick();
    chk("b_cnt_hold", 32'(ifb.ERR_CNT), 32'd255);

    // Reset in the middle of a full buffer
    ifa.OUT_READY = 1'b0;
    ifa.IN_VALID = 1'b1; ifa.OPY_SEL = 2'd1; ifa.OPX_IN = 8'h77;
    tick();
    ifa.OPY_SEL = 2'd2; ifa.OPX_IN = 8'h78;
    tick();
    ifa.IN_VALID = 1'b0;
    chk("mid_full", 32'(ifa.IN_READY), 32'd0);
    chk("mid_opy",  32'(ifa.OPY_OUT),  32'h22);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid",   32'(ifa.OUT_VALID), 32'd0);
    chk("arst_opx",     32'(ifa.OPX_OUT),   32'd0);
    chk("arst_opy",     32'(ifa.OPY_OUT),   32'd0);
    chk("arst_err",     32'(ifa.SEL_ERR),   32'd0);
    chk("arst_ready",   32'(ifa.IN_READY),  32'd1);
    chk("arst_cnt_b",   32'(ifb.ERR_CNT),   32'd0);
    chk("arst_err_b",   32'(ifb.SEL_ERR),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    ifa.OUT_READY = 1'b1;
    tick();
    tick();
    chk("post_no_stale", 32'(ifa.OUT_VALID), 32'd0);
    ifa.IN_VALID = 1'b1; ifa.OPY_SEL = 2'd3; ifa.OPX_IN = 8'hC3;
    tick();
    ifa.IN_VALID = 1'b0;
    chk("post_valid", 32'(ifa.OUT_VALID), 32'd1);
    chk("post_opy",   32'(ifa.OPY_OUT),   32'h44);
    chk("post_opx",   32'(ifa.OPX_OUT),   32'hC3);
    tick();
    chk("post_drain", 32'(ifa.OUT_VALID), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
